// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the PISO shift transmitter.
// Holds the two-state FSM encoding and the default word width.
package shift_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the PISO transmitter: synchronous clear, count enable.
// Registered count, tc_o is combinational from it; no backpressure of its own.
module piso_bit_counter #(
    parameter int WIDTH  = 4,
    parameter int TC_VAL = 2,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TC_VAL));

endmodule

// File: rtl/piso_shift_transmitter.sv
// Parallel-in serial-out transmitter, LSB first, 1-cycle load-to-first-bit latency.
// load_ready high in IDLE and on the ser_last bit; optional parity bit via PISO_PARITY_EN.
module piso_shift_transmitter
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] d,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int SR_W = WIDTH + 1;
`else
    localparam int SR_W = WIDTH;
`endif
    localparam int LAST_IDX = SR_W - 1;

    state_e          state_q, state_d;
    logic [SR_W-1:0] shreg_q, shreg_d;
    logic            ser_out_q, ser_valid_q, ser_last_q, busy_q;
    logic            ser_out_d, ser_valid_d, ser_last_d, busy_d;
    logic            accept, cnt_clear, cnt_en, cnt_tc;

    assign load_ready = ~reset & ((state_q == IDLE) | ser_last_q);
    assign accept     = load_valid & load_ready;
    assign cnt_clear  = accept | ser_last_q;
    assign cnt_en     = (state_q == SHIFT) & ~ser_last_q;

    // Terminal count fires on the penultimate bit so ser_last can be registered.
    piso_bit_counter #(
        .WIDTH  (WIDTH),
        .TC_VAL (LAST_IDX - 1)
    ) u_bit_counter (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        if (accept) begin
            state_d = SHIFT;
`ifdef PISO_PARITY_EN
            shreg_d = {^d, d};
`else
            shreg_d = d;
`endif
        end else if (state_q == SHIFT) begin
            if (ser_last_q) begin
                state_d = IDLE;
                shreg_d = '0;
            end else begin
                shreg_d = shreg_q >> 1;
            end
        end
        busy_d      = (state_d == SHIFT);
        ser_valid_d = busy_d;
        ser_out_d   = busy_d & shreg_d[0];
        ser_last_d  = busy_d & ~accept & cnt_tc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            busy_q      <= busy_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Directed self-checking bench for piso_shift_transmitter (WIDTH=4).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_piso_shift_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [3:0] d;
    logic       load_ready, ser_out, ser_valid, ser_last, busy;

    int errors = 0;
    int checks = 0;

`ifdef PISO_PARITY_EN
    localparam int LEN = 5;
    logic [15:0] exp_b2b = 16'b0000_0010_1001_1011;
`else
    localparam int LEN = 4;
    logic [15:0] exp_b2b = 16'b0000_0000_0100_1011;
`endif

    piso_shift_transmitter #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .d          (d),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b1; d = 4'b1011;
        @(negedge clk);
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_load_ready got %b want 0", load_ready); end
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL rst_ser_valid got %b want 0", ser_valid); end
        checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL rst_ser_out got %b want 0", ser_out); end
        checks++; if (ser_last !== 1'b0) begin errors++; $display("FAIL rst_ser_last got %b want 0", ser_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        reset = 1'b0; load_valid = 1'b0;
        @(negedge clk);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL post_rst_load_ready got %b want 1", load_ready); end
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL post_rst_ser_valid got %b want 0", ser_valid); end
    endtask

    task automatic test_single();
        @(negedge clk);
        load_valid = 1'b1; d = 4'b1011;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", load_ready); end
        for (int i = 0; i < LEN; i++) begin
            @(negedge clk);
            checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL single_valid%0d got %b want 1", i, ser_valid); end
            checks++; if (ser_out !== exp_b2b[i]) begin errors++; $display("FAIL single_bit%0d got %b want %b", i, ser_out, exp_b2b[i]); end
            checks++; if (ser_last !== (i == LEN - 1)) begin errors++; $display("FAIL single_last%0d got %b want %b", i, ser_last, (i == LEN - 1)); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy%0d got %b want 1", i, busy); end
            load_valid = 1'b0; d = 4'b0000;
        end
        @(negedge clk);
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid got %b want 0", ser_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_end_busy got %b want 0", busy); end
        checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL single_end_out got %b want 0", ser_out); end
        checks++; if (ser_last !== 1'b0) begin errors++; $display("FAIL single_end_last got %b want 0", ser_last); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL single_end_ready got %b want 1", load_ready); end
    endtask

    // Also offers d=1111 while the first word is mid-flight; it must be ignored.
    task automatic test_back_to_back();
        @(negedge clk);
        load_valid = 1'b1; d = 4'b1011;
        for (int i = 0; i < 2 * LEN; i++) begin
            @(negedge clk);
            checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %b want 1", i, ser_valid); end
            checks++; if (ser_out !== exp_b2b[i]) begin errors++; $display("FAIL b2b_bit%0d got %b want %b", i, ser_out, exp_b2b[i]); end
            checks++; if (ser_last !== ((i % LEN) == LEN - 1)) begin errors++; $display("FAIL b2b_last%0d got %b want %b", i, ser_last, ((i % LEN) == LEN - 1)); end
            checks++; if (load_ready !== ((i % LEN) == LEN - 1)) begin errors++; $display("FAIL b2b_ready%0d got %b want %b", i, load_ready, ((i % LEN) == LEN - 1)); end
            if (i < LEN - 1) begin
                load_valid = 1'b1; d = 4'b1111;
            end else if (i == LEN - 1) begin
                load_valid = 1'b1; d = 4'b0100;
            end else begin
                load_valid = 1'b0; d = 4'b1111;
            end
        end
        @(negedge clk);
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", ser_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        load_valid = 1'b1; d = 4'b1011;
        @(negedge clk);
        load_valid = 1'b0;
        checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL mid_bit0 got %b want 1", ser_out); end
        @(negedge clk);
        checks++; if (ser_out !== 1'b1 || ser_valid !== 1'b1) begin errors++; $display("FAIL mid_bit1 got out=%b vld=%b want 1 1", ser_out, ser_valid); end
        #1 reset = 1'b1;
        #1;
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", ser_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL mid_rst_out got %b want 0", ser_out); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", load_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", load_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (ser_valid !== 1'b0 || ser_out !== 1'b0) begin errors++; $display("FAIL mid_residual%0d got vld=%b out=%b want 0 0", i, ser_valid, ser_out); end
        end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        logic [4:0] exp_p = 5'b00011;
        @(negedge clk);
        load_valid = 1'b1; d = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            checks++; if (ser_out !== exp_p[i] || ser_valid !== 1'b1) begin errors++; $display("FAIL par_bit%0d got out=%b vld=%b want %b 1", i, ser_out, ser_valid, exp_p[i]); end
            checks++; if (ser_last !== (i == 4)) begin errors++; $display("FAIL par_last%0d got %b want %b", i, ser_last, (i == 4)); end
        end
        @(negedge clk);
        checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL par_end_valid got %b want 0", ser_valid); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
